// File: rtl/adder_16_arbiter_if.sv
// Request/response bundle for adder_16_arbiter: per-requester operand handshake plus one result port.
// With ADDER_ARB_OVF_EN defined, the response also carries the signed-overflow flag rsp_ovf.
interface adder_16_arbiter_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ci;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_co;
`ifdef ADDER_ARB_OVF_EN
    logic                     rsp_ovf;

    modport slave (
        input  req_valid, req_a, req_b, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf
    );

    modport master (
        output req_valid, req_a, req_b, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co, rsp_ovf
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, req_ci, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
    );

    modport master (
        output req_valid, req_a, req_b, req_ci, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
    );
`endif
endinterface

// File: rtl/adder_16_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters; IDLE -> ADD -> RESP.
// Optional feature macro ADDER_ARB_OVF_EN adds the registered signed-overflow output rsp_ovf.
module adder_16_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_16_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [WIDTH:0] add_full(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci
    );
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

`ifdef ADDER_ARB_OVF_EN
    function automatic logic signed_ovf(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] s
    );
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction
`endif

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  cap_a_q, cap_a_d;
    logic [WIDTH-1:0]  cap_b_q, cap_b_d;
    logic              cap_ci_q, cap_ci_d;
    logic [ID_W-1:0]   cap_id_q, cap_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
    logic              rsp_co_q, rsp_co_d;
`ifdef ADDER_ARB_OVF_EN
    logic              rsp_ovf_q, rsp_ovf_d;
`endif

    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      scan_sum;
    logic [WIDTH:0]     add_res;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign op_b[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    // Scan starts one past the last grant and wraps, so every valid requester waits at most NUM_REQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_sum = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && bus.req_valid[scan_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign add_res = add_full(cap_a_q, cap_b_q, cap_ci_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cap_a_d      = cap_a_q;
        cap_b_d      = cap_b_q;
        cap_ci_d     = cap_ci_q;
        cap_id_d     = cap_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_co_d     = rsp_co_q;
`ifdef ADDER_ARB_OVF_EN
        rsp_ovf_d    = rsp_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    cap_a_d      = op_a[grant_idx];
                    cap_b_d      = op_b[grant_idx];
                    cap_ci_d     = bus.req_ci[grant_idx];
                    cap_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ADD;
                end
            end
            ADD: begin
                {rsp_co_d, rsp_sum_d} = add_res;
`ifdef ADDER_ARB_OVF_EN
                rsp_ovf_d   = signed_ovf(cap_a_q, cap_b_q, add_res[WIDTH-1:0]);
`endif
                rsp_id_d    = cap_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cap_a_q      <= '0;
            cap_b_q      <= '0;
            cap_ci_q     <= 1'b0;
            cap_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_co_q     <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cap_a_q      <= cap_a_d;
            cap_b_q      <= cap_b_d;
            cap_ci_q     <= cap_ci_d;
            cap_id_q     <= cap_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_co_q     <= rsp_co_d;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf_q    <= rsp_ovf_d;
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_co    = rsp_co_q;
`ifdef ADDER_ARB_OVF_EN
    assign bus.rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_16_arbiter.sv
// Self-checking bench for adder_16_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin/adder model.
module tb_adder_16_arbiter;
    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_16_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    adder_16_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int mdl_last;

    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];
    logic               op_ci [NUM_REQ];
    logic [NUM_REQ-1:0] vmask;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
            bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
            bus.req_ci[i]               = op_ci[i];
        end
        bus.req_valid = vmask;
    endtask

    // Round-robin reference: first valid index after the previous grant, wrapping.
    function automatic int mdl_pick(input logic [NUM_REQ-1:0] v);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (mdl_last + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_all(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = a; op_b[i] = b; op_ci[i] = ci;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        vmask = '0;
        drive();
        bus.rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        mdl_last = NUM_REQ - 1;
    endtask

    // One complete transaction from IDLE; hold = cycles of rsp_ready=0 in RESP; chg = rewrite winner's operands after accept.
    task automatic do_txn(input string tag, input int hold, input bit chg);
        int g;
        logic [WIDTH:0]     e;
        logic [WIDTH-1:0]   ea, eb;
        logic               eci;
        logic [NUM_REQ-1:0] erdy;
`ifdef ADDER_ARB_OVF_EN
        logic               eovf;
`endif
        drive();
        bus.rsp_ready = (hold == 0);
        #1;
        g = mdl_pick(vmask);
        erdy = (g < 0) ? '0 : (NUM_REQ'(1) << g);
        n_cmp++;
        if (bus.req_ready !== erdy) begin
            n_fail++;
            $display("FAIL %s req_ready got %b want %b", tag, bus.req_ready, erdy);
        end
        if (g < 0) g = 0;
        ea = op_a[g]; eb = op_b[g]; eci = op_ci[g];
        e = (WIDTH+1)'(ea) + (WIDTH+1)'(eb) + (WIDTH+1)'(eci);
`ifdef ADDER_ARB_OVF_EN
        eovf = (ea[WIDTH-1] == eb[WIDTH-1]) && (e[WIDTH-1] != ea[WIDTH-1]);
`endif
        mdl_last = g;
        step();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL %s add_cycle rsp_valid=%b req_ready=%b want 0/0", tag, bus.rsp_valid, bus.req_ready);
        end
        if (chg) begin
            op_a[g] = WIDTH'($urandom);
            op_b[g] = WIDTH'($urandom);
            op_ci[g] = ~op_ci[g];
            drive();
        end
        step();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(g) || {bus.rsp_co, bus.rsp_sum} !== e) begin
            n_fail++;
            $display("FAIL %s result valid=%b id=%0d co/sum=%h want 1/%0d/%h",
                     tag, bus.rsp_valid, bus.rsp_id, {bus.rsp_co, bus.rsp_sum}, g, e);
        end
`ifdef ADDER_ARB_OVF_EN
        n_cmp++;
        if (bus.rsp_ovf !== eovf) begin
            n_fail++;
            $display("FAIL %s rsp_ovf got %b want %b", tag, bus.rsp_ovf, eovf);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            step();
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_W'(g) || {bus.rsp_co, bus.rsp_sum} !== e
                || bus.req_ready !== '0) begin
                n_fail++;
                $display("FAIL %s hold%0d valid=%b id=%0d co/sum=%h rdy=%b want 1/%0d/%h/0",
                         tag, h, bus.rsp_valid, bus.rsp_id, {bus.rsp_co, bus.rsp_sum}, bus.req_ready, g, e);
            end
        end
        bus.rsp_ready = 1'b1;
        step();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || {bus.rsp_co, bus.rsp_sum} !== e) begin
            n_fail++;
            $display("FAIL %s release valid=%b co/sum=%h want 0/%h", tag, bus.rsp_valid, {bus.rsp_co, bus.rsp_sum}, e);
        end
    endtask

    task automatic test_reset();
        set_all('0, '0, 1'b0);
        apply_reset();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_sum !== '0
            || bus.rsp_co !== 1'b0 || bus.req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset valid=%b id=%0d sum=%h co=%b rdy=%b want all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_co, bus.req_ready);
        end
`ifdef ADDER_ARB_OVF_EN
        n_cmp++;
        if (bus.rsp_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset rsp_ovf got %b want 0", bus.rsp_ovf);
        end
`endif
    endtask

    task automatic test_basic();
        set_all('0, '0, 1'b0);
        op_a[0] = 16'h1234; op_b[0] = 16'h0F0F; op_ci[0] = 1'b0;
        vmask = 4'b0001;
        do_txn("basic", 0, 1'b0);
        n_cmp++;
        if (bus.rsp_sum !== 16'h2143 || bus.rsp_co !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_const sum=%h co=%b want 2143/0", bus.rsp_sum, bus.rsp_co);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        set_all(16'hFFFF, 16'h0001, 1'b0);
        vmask = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_txn($sformatf("rr%0d", i), 0, 1'b0);
            n_cmp++;
            if (bus.rsp_id !== ID_W'(i % NUM_REQ) || bus.rsp_sum !== 16'h0000 || bus.rsp_co !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order%0d id=%0d sum=%h co=%b want %0d/0000/1",
                         i, bus.rsp_id, bus.rsp_sum, bus.rsp_co, i % NUM_REQ);
            end
        end
    endtask

    task automatic test_wrap();
        set_all('0, '0, 1'b0);
        op_a[1] = 16'hFFFF; op_b[1] = 16'hFFFF; op_ci[1] = 1'b1;
        vmask = 4'b0010;
        do_txn("wrap_max", 0, 1'b0);
        n_cmp++;
        if (bus.rsp_sum !== 16'hFFFF || bus.rsp_co !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_const sum=%h co=%b want FFFF/1", bus.rsp_sum, bus.rsp_co);
        end
        op_a[3] = 16'h7FFF; op_b[3] = 16'h0001; op_ci[3] = 1'b0;
        vmask = 4'b1000;
        do_txn("ovf_pos", 0, 1'b0);
`ifdef ADDER_ARB_OVF_EN
        n_cmp++;
        if (bus.rsp_ovf !== 1'b1 || bus.rsp_sum !== 16'h8000) begin
            n_fail++;
            $display("FAIL ovf_const ovf=%b sum=%h want 1/8000", bus.rsp_ovf, bus.rsp_sum);
        end
`endif
    endtask

    task automatic test_backpressure();
        op_a[2] = 16'hA5A5; op_b[2] = 16'h1111; op_ci[2] = 1'b1;
        vmask = 4'b0100;
        do_txn("backpressure", 10, 1'b0);
    endtask

    task automatic test_reset_mid();
        op_a[2] = 16'h0F00; op_b[2] = 16'h00F0; op_ci[2] = 1'b0;
        vmask = 4'b0100;
        drive();
        bus.rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== (NUM_REQ'(1) << mdl_pick(vmask))) begin
            n_fail++;
            $display("FAIL rst_mid_grant req_ready got %b want %b", bus.req_ready, NUM_REQ'(1) << mdl_pick(vmask));
        end
        step();
        rst_n = 1'b0;
        vmask = 4'b0101;
        drive();
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_id !== '0 || bus.rsp_co !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid%0d valid=%b sum=%h id=%0d co=%b want 0/0/0/0",
                         i, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_co);
            end
        end
        rst_n = 1'b1;
        mdl_last = NUM_REQ - 1;
        do_txn("after_rst", 0, 1'b0);
        n_cmp++;
        if (bus.rsp_id !== '0) begin
            n_fail++;
            $display("FAIL after_rst_winner id=%0d want 0", bus.rsp_id);
        end
    endtask

    task automatic test_operand_change();
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                op_a[r] = WIDTH'($urandom); op_b[r] = WIDTH'($urandom); op_ci[r] = 1'($urandom);
            end
            vmask = NUM_REQ'(1) << i;
            do_txn($sformatf("opchg%0d", i), 0, 1'b1);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int t = 0; t < 80; t++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                op_a[r] = WIDTH'($urandom); op_b[r] = WIDTH'($urandom); op_ci[r] = 1'($urandom);
            end
            vmask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            do_txn($sformatf("rand%0d", t), int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        vmask = '0;
        mdl_last = NUM_REQ - 1;
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_operand_change();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
